// File: rtl/window_stream_buffer.sv
// Streaming sliding-window generator. Pixels arrive one per accepted beat in
// raster order; the block tracks its own row/column and emits a registered
// FILTER_SIZE x FILTER_SIZE window at every position selected by STRIDE.

// One window row: FILTER_SIZE-1 shift registers plus the newest column tap.
module window_stream_buffer_row #(
  parameter int F  = 3,
  parameter int PW = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [PW-1:0]     col_in,
  output logic [F*PW-1:0]   row_pix
);
  logic [F-2:0][PW-1:0] win;

  // Shift the row left by one column on every accepted beat.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int j = 0; j < F-2; j++) win[j] <= win[j+1];
      win[F-2] <= col_in;
    end
  end

  // Element j=0 is the leftmost column; the newest column sits on top.
  assign row_pix = {col_in, win};
endmodule

module window_stream_buffer #(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int D_WIDTH      = 8,
  parameter int CHANNELS     = 1,
  parameter int STRIDE       = 1,
  localparam int PW  = CHANNELS*D_WIDTH,
  localparam int RW  = $clog2(IMAGE_HEIGHT),
  localparam int CW  = $clog2(IMAGE_WIDTH),
  localparam int SW  = (STRIDE > 1) ? $clog2(STRIDE) : 1,
  // Line-buffer depth: together with the F-1 row registers this delays a
  // pixel by exactly one image row, so the buffer tail is pixel (r-1, c).
  localparam int LBD = IMAGE_WIDTH-FILTER_SIZE+1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  input  logic [PW-1:0]                             in_data,
  output logic                                      out_valid,
  output logic [PW*FILTER_SIZE*FILTER_SIZE-1:0]     out_data,
  output logic [RW-1:0]                             out_row,
  output logic [CW-1:0]                             out_col,
  output logic                                      frame_done
);
  localparam int F = FILTER_SIZE;

  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [SW-1:0] rph, cph;
  logic          row_end, frame_end, emit;

  logic [F-1:0][F*PW-1:0] row_pix;

  assign row_end   = (c == CW'(IMAGE_WIDTH-1));
  assign frame_end = row_end && (r == RW'(IMAGE_HEIGHT-1));
  // Position gates keep stale rows and row-straddling windows out; the phase
  // counters implement the stride test without dividers.
  assign emit = in_valid && (r >= RW'(F-1)) && (c >= CW'(F-1)) &&
                (rph == '0) && (cph == '0);

  // Per-row storage: row F-1 takes the live pixel, each older row takes the
  // tail of a line buffer fed from the row below it.
  for (genvar i = 0; i < F; i++) begin : g_row
    logic [PW-1:0] col_i;
    if (i == F-1) begin : g_live
      assign col_i = in_data;
    end else begin : g_lb
      logic [LBD-1:0][PW-1:0] lb;
      // Line buffer advances only on accepted beats; contents are never reset.
      always_ff @(posedge clk) begin
        if (in_valid) begin
          lb[0] <= row_pix[i+1][PW-1:0];
          for (int k = 1; k < LBD; k++) lb[k] <= lb[k-1];
        end
      end
      assign col_i = lb[LBD-1];
    end
    window_stream_buffer_row #(.F(F), .PW(PW)) u_row (
      .clk     (clk),
      .en      (in_valid),
      .col_in  (col_i),
      .row_pix (row_pix[i])
    );
  end

  // Raster position and stride phase tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      c   <= '0;
      rph <= '0;
      cph <= '0;
    end else if (in_valid) begin
      if (row_end) begin
        c   <= '0;
        cph <= '0;
        if (frame_end) begin
          r   <= '0;
          rph <= '0;
        end else begin
          r <= r + RW'(1);
          if (r >= RW'(F-1)) rph <= (rph == SW'(STRIDE-1)) ? '0 : rph + SW'(1);
        end
      end else begin
        c <= c + CW'(1);
        if (c >= CW'(F-1)) cph <= (cph == SW'(STRIDE-1)) ? '0 : cph + SW'(1);
      end
    end
  end

  // Registered window output; data and position hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= in_valid && frame_end;
      if (emit) begin
        out_data <= row_pix;
        out_row  <= r - RW'(F-1);
        out_col  <= c - CW'(F-1);
      end
    end
  end
endmodule

// File: tb/tb_window_stream_buffer.sv
// Bench for window_stream_buffer: three 5x5 instances (stride 1, stride 2,
// three channels) driven in raster order; expected windows are computed from
// the pixel formula, queued when the pixel is driven, and popped on out_valid.
module tb_window_stream_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_vld, a_ov, a_fd;
  logic [7:0]   a_data;
  logic [71:0]  a_od;
  logic [2:0]   a_row, a_col;

  logic         s_vld, s_ov, s_fd;
  logic [7:0]   s_data;
  logic [71:0]  s_od;
  logic [2:0]   s_row, s_col;

  logic         m_vld, m_ov, m_fd;
  logic [23:0]  m_data;
  logic [215:0] m_od;
  logic [2:0]   m_row, m_col;

  window_stream_buffer #(.FILTER_SIZE(3), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5),
    .D_WIDTH(8), .CHANNELS(1), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_vld), .in_data(a_data), .out_valid(a_ov),
    .out_data(a_od), .out_row(a_row), .out_col(a_col), .frame_done(a_fd));

  window_stream_buffer #(.FILTER_SIZE(3), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5),
    .D_WIDTH(8), .CHANNELS(1), .STRIDE(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_vld), .in_data(s_data), .out_valid(s_ov),
    .out_data(s_od), .out_row(s_row), .out_col(s_col), .frame_done(s_fd));

  window_stream_buffer #(.FILTER_SIZE(3), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5),
    .D_WIDTH(8), .CHANNELS(3), .STRIDE(1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(m_vld), .in_data(m_data), .out_valid(m_ov),
    .out_data(m_od), .out_row(m_row), .out_col(m_col), .frame_done(m_fd));

  typedef struct {
    logic [215:0] data;
    int           row;
    int           col;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  // Window whose top-left pixel is (r0,c0); pixel value = base+5r+c+64ch.
  function automatic logic [215:0] exp_win(input int base, input int r0, input int c0, input int chs);
    logic [215:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        for (int ch = 0; ch < chs; ch++)
          w[((i*3+j)*chs+ch)*8 +: 8] = 8'(base + 5*(r0+i) + (c0+j) + 64*ch);
    return w;
  endfunction

  // Stream npix pixels of one frame into dut_a with optional random gaps,
  // checking every cycle's pulses and every emitted window.
  task automatic drive_a(input int base, input int gap_pct, input int npix, output int nwin);
    exp_t e;
    logic exp_ov;
    nwin = 0;
    for (int n = 0; n < npix; n++) begin
      int r = n / 5;
      int c = n % 5;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        a_vld = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if (a_ov !== 1'b0 || a_fd !== 1'b0) begin
          nerr++;
          $display("FAIL gap_idle: out_valid=%b frame_done=%b, required 0/0", a_ov, a_fd);
        end
      end
      a_vld  = 1'b1;
      a_data = 8'(base + n);
      exp_ov = (r >= 2 && c >= 2);
      if (exp_ov) q.push_back('{exp_win(base, r-2, c-2, 1), r-2, c-2});
      @(posedge clk); #1;
      nvec++;
      if (a_ov !== exp_ov || a_fd !== (n == 24)) begin
        nerr++;
        $display("FAIL a_pulses pix=%0d: out_valid=%b frame_done=%b, required %b/%b",
                 n, a_ov, a_fd, exp_ov, (n == 24));
      end
      if (a_ov === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        nwin++;
        nvec++;
        if (a_od !== e.data[71:0] || a_row !== e.row[2:0] || a_col !== e.col[2:0]) begin
          nerr++;
          $display("FAIL a_window pix=%0d: got %h @(%0d,%0d), required %h @(%0d,%0d)",
                   n, a_od, a_row, a_col, e.data[71:0], e.row, e.col);
        end
      end
    end
    a_vld = 1'b0;
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL a_queue_drain: %0d windows not emitted, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_vld = 1'b0; s_vld = 1'b0; m_vld = 1'b0;
    a_data = '0; s_data = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (a_ov !== 1'b0 || a_fd !== 1'b0 || a_od !== '0 || a_row !== '0 || a_col !== '0 ||
        s_ov !== 1'b0 || m_ov !== 1'b0 || m_od !== '0) begin
      nerr++;
      $display("FAIL reset_state: a_ov=%b a_fd=%b a_od=%h row=%0d col=%0d s_ov=%b m_ov=%b, required all 0",
               a_ov, a_fd, a_od, a_row, a_col, s_ov, m_ov);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int nw;
    logic [215:0] last;
    drive_a(0, 0, 25, nw);
    nvec++;
    if (nw != 9) begin
      nerr++;
      $display("FAIL basic_count: %0d windows, required 9", nw);
    end
    // idle cycle: pulses drop, data and position hold the last window
    last = exp_win(0, 2, 2, 1);
    @(posedge clk); #1;
    nvec++;
    if (a_ov !== 1'b0 || a_fd !== 1'b0 || a_od !== last[71:0] || a_row !== 3'd2 || a_col !== 3'd2) begin
      nerr++;
      $display("FAIL basic_hold: ov=%b fd=%b od=%h @(%0d,%0d), required 0/0 %h @(2,2)",
               a_ov, a_fd, a_od, a_row, a_col, last[71:0]);
    end
  endtask

  task automatic test_random_gaps;
    int nw;
    drive_a(0, 35, 25, nw);
    nvec++;
    if (nw != 9) begin
      nerr++;
      $display("FAIL gaps_count: %0d windows, required 9", nw);
    end
  endtask

  task automatic test_back_to_back;
    int nw1, nw2;
    drive_a(0, 0, 25, nw1);
    drive_a(100, 0, 25, nw2);
    nvec++;
    if (nw1 != 9 || nw2 != 9) begin
      nerr++;
      $display("FAIL b2b_count: %0d/%0d windows, required 9/9", nw1, nw2);
    end
  endtask

  task automatic test_reset_mid;
    int nw;
    drive_a(0, 0, 18, nw);
    nvec++;
    if (nw != 4) begin
      nerr++;
      $display("FAIL midrst_partial: %0d windows, required 4", nw);
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (a_ov !== 1'b0 || a_fd !== 1'b0 || a_od !== '0 || a_row !== '0 || a_col !== '0) begin
      nerr++;
      $display("FAIL midrst_outputs: ov=%b fd=%b od=%h @(%0d,%0d), required all 0",
               a_ov, a_fd, a_od, a_row, a_col);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    drive_a(0, 0, 25, nw);
    nvec++;
    if (nw != 9) begin
      nerr++;
      $display("FAIL midrst_fresh: %0d windows, required 9", nw);
    end
  endtask

  task automatic test_stride;
    exp_t e;
    logic exp_ov;
    int nw = 0;
    for (int n = 0; n < 25; n++) begin
      int r = n / 5;
      int c = n % 5;
      s_vld  = 1'b1;
      s_data = 8'(n);
      exp_ov = (r >= 2 && c >= 2 && (r % 2) == 0 && (c % 2) == 0);
      if (exp_ov) q.push_back('{exp_win(0, r-2, c-2, 1), r-2, c-2});
      @(posedge clk); #1;
      nvec++;
      if (s_ov !== exp_ov || s_fd !== (n == 24)) begin
        nerr++;
        $display("FAIL stride_pulses pix=%0d: out_valid=%b frame_done=%b, required %b/%b",
                 n, s_ov, s_fd, exp_ov, (n == 24));
      end
      if (s_ov === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        nw++;
        nvec++;
        if (s_od !== e.data[71:0] || s_row !== e.row[2:0] || s_col !== e.col[2:0]) begin
          nerr++;
          $display("FAIL stride_window pix=%0d: got %h @(%0d,%0d), required %h @(%0d,%0d)",
                   n, s_od, s_row, s_col, e.data[71:0], e.row, e.col);
        end
      end
    end
    s_vld = 1'b0;
    nvec++;
    if (nw != 4 || q.size() != 0) begin
      nerr++;
      $display("FAIL stride_count: %0d windows (%0d left), required 4 (0 left)", nw, q.size());
      q.delete();
    end
  endtask

  task automatic test_multichannel;
    exp_t e;
    logic exp_ov;
    int nw = 0;
    for (int n = 0; n < 25; n++) begin
      int r = n / 5;
      int c = n % 5;
      m_vld  = 1'b1;
      m_data = {8'(n + 128), 8'(n + 64), 8'(n)};
      exp_ov = (r >= 2 && c >= 2);
      if (exp_ov) q.push_back('{exp_win(0, r-2, c-2, 3), r-2, c-2});
      @(posedge clk); #1;
      nvec++;
      if (m_ov !== exp_ov || m_fd !== (n == 24)) begin
        nerr++;
        $display("FAIL mc_pulses pix=%0d: out_valid=%b frame_done=%b, required %b/%b",
                 n, m_ov, m_fd, exp_ov, (n == 24));
      end
      if (m_ov === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        nw++;
        if (nw == 1) begin
          nvec++;
          if (m_od[112 +: 8] !== 8'd134) begin
            nerr++;
            $display("FAIL mc_elem11_ch2: got %0d, required 134", m_od[112 +: 8]);
          end
        end
        nvec++;
        if (m_od !== e.data || m_row !== e.row[2:0] || m_col !== e.col[2:0]) begin
          nerr++;
          $display("FAIL mc_window pix=%0d: got %h @(%0d,%0d), required %h @(%0d,%0d)",
                   n, m_od, m_row, m_col, e.data, e.row, e.col);
        end
      end
    end
    m_vld = 1'b0;
    nvec++;
    if (nw != 9 || q.size() != 0) begin
      nerr++;
      $display("FAIL mc_count: %0d windows (%0d left), required 9 (0 left)", nw, q.size());
      q.delete();
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random_gaps;
    test_back_to_back;
    test_reset_mid;
    test_stride;
    test_multichannel;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
